// File: rtl/rtc_pkg.sv
// Shared types and constants for the RTC read sequencer: FSM encoding,
// default RTC register addresses, register index constants and a BCD helper.
package rtc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_GAP1,
    ST_DATA,
    ST_GAP2,
    ST_COMMIT
  } state_t;

  localparam int NUM_REGS = 6;

  // Register indices, in the order they are read from the RTC
  localparam int SEG  = 0;
  localparam int MIN  = 1;
  localparam int HORA = 2;
  localparam int DIA  = 3;
  localparam int MES  = 4;
  localparam int ANO  = 5;

  typedef logic [2:0] idx_t;

  localparam logic [7:0] ADDR_SEG_DFLT  = 8'h21;
  localparam logic [7:0] ADDR_MIN_DFLT  = 8'h22;
  localparam logic [7:0] ADDR_HORA_DFLT = 8'h23;
  localparam logic [7:0] ADDR_DIA_DFLT  = 8'h24;
  localparam logic [7:0] ADDR_MES_DFLT  = 8'h25;
  localparam logic [7:0] ADDR_ANO_DFLT  = 8'h26;

  function automatic logic is_bcd(input logic [7:0] value);
    return (value[7:4] <= 4'd9) && (value[3:0] <= 4'd9);
  endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// Bus phase timer: loadable down-counter whose last flag marks the final
// clock of every PHASE_CYCLES-long bus phase.
module rtc_phase_timer #(
  parameter int PHASE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic last
);

  localparam int CW = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(PHASE_CYCLES - 1);

  logic [CW-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= LOAD_VAL;
    end else if (load) begin
      count <= LOAD_VAL;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign last = (count == '0);

endmodule

// File: rtl/rtc_read_sequencer.sv
// Periodic RTC burst reader: fetches seconds..year over the multiplexed AD
// bus into shadows and commits them atomically. Option macro: RTC_BCD_CHECK_EN.
module rtc_read_sequencer
  import rtc_pkg::*;
#(
  parameter int         PHASE_CYCLES   = 4,
  parameter int         REFRESH_CYCLES = 1000000,
  parameter logic [7:0] ADDR_SEG       = ADDR_SEG_DFLT,
  parameter logic [7:0] ADDR_MIN       = ADDR_MIN_DFLT,
  parameter logic [7:0] ADDR_HORA      = ADDR_HORA_DFLT,
  parameter logic [7:0] ADDR_DIA       = ADDR_DIA_DFLT,
  parameter logic [7:0] ADDR_MES       = ADDR_MES_DFLT,
  parameter logic [7:0] ADDR_ANO       = ADDR_ANO_DFLT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] ad_in,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       a_d,
  output logic [7:0] fechas,
  output logic [7:0] fechamin,
  output logic [7:0] fechah,
  output logic [7:0] fechad,
  output logic [7:0] fecham,
  output logic [7:0] fechaa,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int RCW = (REFRESH_CYCLES > 2) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [RCW-1:0] REFRESH_LAST = RCW'(REFRESH_CYCLES - 1);

  state_t     state, state_nx;
  idx_t       idx;
  logic [RCW-1:0] refresh_cnt;
  logic       tick, trigger;
  logic       phase_last, timer_load;
  logic       capture, commit_ok;
  logic [7:0] addr_sel;
  logic [7:0] shadow [NUM_REGS];
  logic [7:0] fecha  [NUM_REGS];

  assign tick    = (refresh_cnt == REFRESH_LAST);
  assign trigger = start | tick;
  assign capture = (state == ST_DATA) && phase_last;

  always_ff @(posedge clk) begin
    if (rst || tick) begin
      refresh_cnt <= '0;
    end else begin
      refresh_cnt <= refresh_cnt + 1'b1;
    end
  end

  // Held loaded while idle so the first phase starts with a full count
  assign timer_load = (state == ST_IDLE) | phase_last;

  rtc_phase_timer #(.PHASE_CYCLES(PHASE_CYCLES)) u_phase_timer (
    .clk  (clk),
    .rst  (rst),
    .load (timer_load),
    .last (phase_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:   if (trigger)    state_nx = ST_ADDR;
      ST_ADDR:   if (phase_last) state_nx = ST_GAP1;
      ST_GAP1:   if (phase_last) state_nx = ST_DATA;
      ST_DATA:   if (phase_last) state_nx = ST_GAP2;
      ST_GAP2:   if (phase_last) state_nx = (idx == idx_t'(ANO)) ? ST_COMMIT : ST_ADDR;
      ST_COMMIT: state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    addr_sel = 8'h00;
    case (idx)
      idx_t'(SEG):  addr_sel = ADDR_SEG;
      idx_t'(MIN):  addr_sel = ADDR_MIN;
      idx_t'(HORA): addr_sel = ADDR_HORA;
      idx_t'(DIA):  addr_sel = ADDR_DIA;
      idx_t'(MES):  addr_sel = ADDR_MES;
      idx_t'(ANO):  addr_sel = ADDR_ANO;
      default:      addr_sel = 8'h00;
    endcase
  end

  // Bus pins decode straight from state, so leaving ADDR or reset frees the bus at that edge
  always_comb begin
    cs_n   = 1'b1;
    rd_n   = 1'b1;
    wr_n   = 1'b1;
    a_d    = 1'b0;
    ad_oe  = 1'b0;
    ad_out = 8'h00;
    case (state)
      ST_ADDR: begin
        cs_n   = 1'b0;
        wr_n   = 1'b0;
        ad_oe  = 1'b1;
        ad_out = addr_sel;
      end
      ST_DATA: begin
        cs_n = 1'b0;
        rd_n = 1'b0;
        a_d  = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
    end else if (state == ST_COMMIT) begin
      idx <= '0;
    end else if (state == ST_GAP2 && phase_last && idx != idx_t'(ANO)) begin
      idx <= idx + 1'b1;
    end
  end

  // NOTE: the shadow file has no reset; each burst rewrites all six entries
  // before COMMIT can copy them, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (capture) begin
      shadow[idx] <= ad_in;
    end
  end

`ifdef RTC_BCD_CHECK_EN
  logic burst_bad;

  always_ff @(posedge clk) begin
    if (rst) begin
      burst_bad <= 1'b0;
      err       <= 1'b0;
    end else begin
      if (state == ST_IDLE && trigger) begin
        burst_bad <= 1'b0;
      end else if (capture && !is_bcd(ad_in)) begin
        burst_bad <= 1'b1;
      end
      if (state == ST_COMMIT && burst_bad) begin
        err <= 1'b1;
      end
    end
  end

  assign commit_ok = !burst_bad;
`else
  assign commit_ok = 1'b1;
  assign err       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      done <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        fecha[i] <= 8'h00;
      end
    end else begin
      done <= (state == ST_COMMIT);
      if (state == ST_COMMIT && commit_ok) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          fecha[i] <= shadow[i];
        end
      end
    end
  end

  assign fechas   = fecha[SEG];
  assign fechamin = fecha[MIN];
  assign fechah   = fecha[HORA];
  assign fechad   = fecha[DIA];
  assign fecham   = fecha[MES];
  assign fechaa   = fecha[ANO];

endmodule

// File: tb/tb_rtc_read_sequencer.sv
// Self-checking bench for rtc_read_sequencer: behavioural RTC register model,
// bus-phase recorder and directed/randomized bursts checked with assertions.
module tb_rtc_read_sequencer;

  localparam int P   = 4;
  localparam int R   = 200;
  localparam int LAT = 1 + 24 * P + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] ad_in;
  logic [7:0] ad_out;
  logic       ad_oe, cs_n, rd_n, wr_n, a_d;
  logic [7:0] fechas, fechamin, fechah, fechad, fecham, fechaa;
  logic       busy, done, err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rtc_read_sequencer #(.PHASE_CYCLES(P), .REFRESH_CYCLES(R)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .ad_in    (ad_in),
    .ad_out   (ad_out),
    .ad_oe    (ad_oe),
    .cs_n     (cs_n),
    .rd_n     (rd_n),
    .wr_n     (wr_n),
    .a_d      (a_d),
    .fechas   (fechas),
    .fechamin (fechamin),
    .fechah   (fechah),
    .fechad   (fechad),
    .fecham   (fecham),
    .fechaa   (fechaa),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  // RTC model: latches the address written in the address phase, returns its register
  logic [7:0] mem [6];
  logic [7:0] lat_addr = 8'h21;

  always @(posedge clk)
    if (!cs_n && !wr_n && !a_d && ad_oe) lat_addr <= ad_out;

  always_comb begin
    case (lat_addr)
      8'h21:   ad_in = mem[0];
      8'h22:   ad_in = mem[1];
      8'h23:   ad_in = mem[2];
      8'h24:   ad_in = mem[3];
      8'h25:   ad_in = mem[4];
      8'h26:   ad_in = mem[5];
      default: ad_in = 8'hFF;
    endcase
  end

  int since_rst = 0;
  always @(posedge clk)
    if (rst) since_rst <= 0;
    else     since_rst <= since_rst + 1;

  // Bus recorder: one code per busy cycle (address byte, 1 = gap/idle, 2 = data)
  logic [7:0] bus_q[$];
  int done_cnt = 0, rise_cnt = 0, last_rise_at = -1, viol = 0;
  logic busy_d = 1'b0;

  function automatic logic [7:0] classify(input logic cs, rd, wr, ad, oe, input logic [7:0] d);
    if (!cs && !wr && rd && !ad && oe) return d;
    if (!cs && !rd && wr && ad && !oe) return 8'h02;
    if (cs && rd && wr && !oe)         return 8'h01;
    return 8'hEE;
  endfunction

  always @(negedge clk) begin
    if (busy) bus_q.push_back(classify(cs_n, rd_n, wr_n, a_d, ad_oe, ad_out));
    if (done) done_cnt++;
    if (busy && !busy_d) begin
      rise_cnt++;
      last_rise_at = since_rst;
    end
    busy_d = busy;
    if (ad_oe && !rd_n) viol++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  function automatic logic [7:0] rand_bcd();
    logic [3:0] hi, lo;
    hi = 4'($urandom_range(9));
    lo = 4'($urandom_range(9));
    return {hi, lo};
  endfunction

  task automatic randomize_mem();
    for (int i = 0; i < 6; i++) mem[i] = rand_bcd();
  endtask

  function automatic logic [47:0] mem_word();
    return {mem[5], mem[4], mem[3], mem[2], mem[1], mem[0]};
  endfunction

  function automatic logic [47:0] fecha_word();
    return {fechaa, fecham, fechad, fechah, fechamin, fechas};
  endfunction

  // Pulse start for one edge and wait (bounded) for done; n counts edges from acceptance
  task automatic run_burst(output int n);
    bus_q.delete();
    start = 1'b1;
    step();
    start = 1'b0;
    n = 1;
    while (!done && n < LAT + 50) begin
      step();
      n++;
    end
  endtask

  task automatic check_bus(input string tag);
    logic [7:0] eq[$];
    int first_bad;
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < P; k++) eq.push_back(8'(8'h21 + i));
      for (int k = 0; k < P; k++) eq.push_back(8'h01);
      for (int k = 0; k < P; k++) eq.push_back(8'h02);
      for (int k = 0; k < P; k++) eq.push_back(8'h01);
    end
    eq.push_back(8'h01);
    check({tag, "_len"}, 64'(bus_q.size()), 64'(eq.size()));
    first_bad = 0;
    for (int i = 0; i < eq.size() && i < bus_q.size(); i++) begin
      if (bus_q[i] !== eq[i]) begin
        first_bad = i;
        break;
      end
    end
    if (bus_q.size() > first_bad) check({tag, "_seq"}, 64'(bus_q[first_bad]), 64'(eq[first_bad]));
  endtask

  initial begin
    int n;
    logic [47:0] prev, exp;

    mem[0] = 8'h45; mem[1] = 8'h30; mem[2] = 8'h12;
    mem[3] = 8'h07; mem[4] = 8'h04; mem[5] = 8'h17;

    // Reset state
    do_reset();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_bus", 64'({cs_n, rd_n, wr_n, a_d, ad_oe}), 64'(5'b11100));
    check("rst_ad_out", 64'(ad_out), 64'h00);
    check("rst_fecha", 64'(fecha_word()), 64'h0);

    // 1: fixed-value burst
    bus_q.delete();
    start = 1'b1;
    step();
    start = 1'b0;
    check("t1_busy_after_accept", 64'(busy), 64'd1);
    n = 1;
    while (!done && n < LAT + 50) begin
      step();
      n++;
    end
    check("t1_latency", 64'(n), 64'(LAT));
    check("t1_fecha", 64'(fecha_word()), 64'h17_04_07_12_30_45);
    check_bus("t1_bus");
    step();
    check("t1_done_one_cycle", 64'(done), 64'd0);
    check("t1_idle_busy", 64'(busy), 64'd0);

    // 2: data changes mid-burst; display holds old values until the commit edge
    prev = fecha_word();
    randomize_mem();
    exp = {8'h99, 8'h99, 8'h99, 8'h99, 8'h99, mem[0]};
    start = 1'b1;
    step();
    start = 1'b0;
    n = 1;
    while (!(ad_oe && ad_out == 8'h22) && n < LAT) begin
      step();
      n++;
    end
    check("t2_min_addr_seen", 64'(ad_out), 64'h22);
    for (int i = 0; i < 6; i++) mem[i] = 8'h99;
    while (n < LAT - 1) begin
      step();
      n++;
    end
    check("t2_hold_before_commit", 64'(fecha_word()), 64'(prev));
    step();
    check("t2_done", 64'(done), 64'd1);
    check("t2_fecha", 64'(fecha_word()), 64'(exp));

    // 3: start pulses during a burst are dropped
    do_reset();
    randomize_mem();
    exp = mem_word();
    done_cnt = 0;
    rise_cnt = 0;
    start = 1'b1;
    step();
    n = 1;
    for (int k = 2; k <= 150; k++) begin
      start = (k == 10 || k == 50);
      step();
    end
    start = 1'b0;
    check("t3_done_count", 64'(done_cnt), 64'd1);
    check("t3_burst_count", 64'(rise_cnt), 64'd1);
    check("t3_fecha", 64'(fecha_word()), 64'(exp));

    // 4: automatic refresh bursts, and start coinciding with a refresh tick
    do_reset();
    randomize_mem();
    exp = mem_word();
    done_cnt = 0;
    rise_cnt = 0;
    while (rise_cnt < 1 && since_rst < R + 60) step();
    check("t4_first_tick", 64'(last_rise_at), 64'(R));
    while (rise_cnt < 2 && since_rst < 2 * R + 60) step();
    check("t4_second_tick", 64'(last_rise_at), 64'(2 * R));
    check("t4_fecha_auto", 64'(fecha_word()), 64'(exp));
    while (since_rst < 3 * R - 1) step();
    randomize_mem();
    exp = mem_word();
    start = 1'b1;
    step();
    start = 1'b0;
    while (since_rst < 3 * R + 150) step();
    check("t4_coincident_bursts", 64'(rise_cnt), 64'd3);
    check("t4_coincident_dones", 64'(done_cnt), 64'd3);
    check("t4_third_tick", 64'(last_rise_at), 64'(3 * R));
    check("t4_fecha_coincident", 64'(fecha_word()), 64'(exp));

    // 5: reset in the middle of an automatic burst
    randomize_mem();
    while (since_rst < 4 * R + 39) step();
    check("t5_busy_before_rst", 64'(busy), 64'd1);
    rst = 1'b1;
    step();
    check("t5_bus_released", 64'({cs_n, rd_n, wr_n, ad_oe}), 64'(4'b1110));
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_fecha_cleared", 64'(fecha_word()), 64'h0);
    rst = 1'b0;
    done_cnt = 0;
    for (int k = 0; k < 120; k++) step();
    check("t5_no_commit_after_rst", 64'(done_cnt), 64'd0);
    check("t5_fecha_still_zero", 64'(fecha_word()), 64'h0);

    // 6: non-BCD month byte
    do_reset();
    randomize_mem();
    prev = mem_word();
    run_burst(n);
    check("t6_good_fecha", 64'(fecha_word()), 64'(prev));
    check("t6_good_err", 64'(err), 64'd0);
    mem[4] = 8'h1A;
    exp = mem_word();
    run_burst(n);
    check("t6_bad_latency", 64'(n), 64'(LAT));
`ifdef RTC_BCD_CHECK_EN
    check("t6_bad_fecha_kept", 64'(fecha_word()), 64'(prev));
    step();
    check("t6_bad_err", 64'(err), 64'd1);
`else
    check("t6_bad_fecha_committed", 64'(fecha_word()), 64'(exp));
    step();
    check("t6_bad_err", 64'(err), 64'd0);
`endif
    randomize_mem();
    exp = mem_word();
    run_burst(n);
    check("t6_recover_fecha", 64'(fecha_word()), 64'(exp));
`ifdef RTC_BCD_CHECK_EN
    check("t6_err_sticky", 64'(err), 64'd1);
`else
    check("t6_err_tied", 64'(err), 64'd0);
`endif

    check("oe_rd_never_overlap", 64'(viol), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
